// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Latency: one cycle ID->EX; flush squashes, hold freezes, hazard inserts one bubble and raises stall.
module id_ex_pipeline_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic [4:0]  rd_id,
    input  logic [31:0] rs1_data_id,
    input  logic [31:0] rs2_data_id,
    input  logic [31:0] imm_id,
    input  logic [31:0] pc_id,
    input  logic        RegWrite_id,
    input  logic        MemRead_id,
    input  logic        MemWrite_id,
    input  logic        MemtoReg_id,
    input  logic        ALUSrc_id,
    input  logic        Branch_id,
    input  logic [1:0]  ALUOp_id,
    input  logic        uses_rs2_id,
    input  logic        valid_id,
    input  logic        flush,
    input  logic        hold,
    output logic [4:0]  rs1_ex,
    output logic [4:0]  rs2_ex,
    output logic [4:0]  rd_ex,
    output logic [31:0] rs1_data_ex,
    output logic [31:0] rs2_data_ex,
    output logic [31:0] imm_ex,
    output logic [31:0] pc_ex,
    output logic        RegWrite_ex,
    output logic        MemRead_ex,
    output logic        MemWrite_ex,
    output logic        MemtoReg_ex,
    output logic        ALUSrc_ex,
    output logic        Branch_ex,
    output logic [1:0]  ALUOp_ex,
    output logic        uses_rs2_ex,
    output logic        valid_ex,
    output logic        stall,
    output logic [15:0] stall_count
);

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        branch;
        logic [1:0]  alu_op;
        logic        uses_rs2;
        logic        valid;
    } idex_t;

    idex_t       id_s;
    idex_t       ex_q, ex_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        hazard;

    assign id_s = {rs1_id, rs2_id, rd_id, rs1_data_id, rs2_data_id, imm_id, pc_id,
                   RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id, ALUSrc_id, Branch_id,
                   ALUOp_id, uses_rs2_id, valid_id};

    // rd==0 never carries a real result, so a load to x0 cannot create a dependency
    assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & valid_id &
                    ((ex_q.rd == rs1_id) | (uses_rs2_id & (ex_q.rd == rs2_id)));

    assign stall = (hazard | hold) & ~flush;

    always_comb begin
        ex_d          = ex_q;
        stall_count_d = stall_count_q;
        if (flush) begin
            ex_d = '0;
        end else if (!hold) begin
            ex_d = id_s;
            // bubble: strip everything the forwarding unit or EX could act on
            if (hazard || !valid_id) begin
                ex_d.rd         = 5'd0;
                ex_d.reg_write  = 1'b0;
                ex_d.mem_read   = 1'b0;
                ex_d.mem_write  = 1'b0;
                ex_d.mem_to_reg = 1'b0;
                ex_d.alu_src    = 1'b0;
                ex_d.branch     = 1'b0;
                ex_d.alu_op     = 2'b00;
                ex_d.valid      = 1'b0;
            end
            if (hazard && (stall_count_q != 16'hFFFF)) begin
                stall_count_d = stall_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q          <= '0;
            stall_count_q <= 16'd0;
        end else begin
            ex_q          <= ex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign rs1_ex      = ex_q.rs1;
    assign rs2_ex      = ex_q.rs2;
    assign rd_ex       = ex_q.rd;
    assign rs1_data_ex = ex_q.rs1_data;
    assign rs2_data_ex = ex_q.rs2_data;
    assign imm_ex      = ex_q.imm;
    assign pc_ex       = ex_q.pc;
    assign RegWrite_ex = ex_q.reg_write;
    assign MemRead_ex  = ex_q.mem_read;
    assign MemWrite_ex = ex_q.mem_write;
    assign MemtoReg_ex = ex_q.mem_to_reg;
    assign ALUSrc_ex   = ex_q.alu_src;
    assign Branch_ex   = ex_q.branch;
    assign ALUOp_ex    = ex_q.alu_op;
    assign uses_rs2_ex = ex_q.uses_rs2;
    assign valid_ex    = ex_q.valid;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: directed instruction stream, expected EX state queued per cycle.
module tb_id_ex_pipeline_reg;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        as;
        logic        br;
        logic [1:0]  op;
        logic        u2;
        logic        v;
    } rec_t;

    typedef struct packed {
        rec_t        e;
        logic        dc;
        logic        stall;
        logic [15:0] cnt;
    } exp_t;

    localparam int K_LOAD = 0;
    localparam int K_HAZ  = 1;
    localparam int K_HOLD = 2;
    localparam int K_BUB  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    rec_t        id_in;
    logic        flush, hold;
    rec_t        act;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex;
    logic [31:0] rs1_data_ex, rs2_data_ex, imm_ex, pc_ex;
    logic        RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrc_ex, Branch_ex;
    logic [1:0]  ALUOp_ex;
    logic        uses_rs2_ex, valid_ex, stall;
    logic [15:0] stall_count;

    exp_t sbq[$];
    rec_t prev_e;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    id_ex_pipeline_reg dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(id_in.rs1), .rs2_id(id_in.rs2), .rd_id(id_in.rd),
        .rs1_data_id(id_in.d1), .rs2_data_id(id_in.d2), .imm_id(id_in.imm), .pc_id(id_in.pc),
        .RegWrite_id(id_in.rw), .MemRead_id(id_in.mr), .MemWrite_id(id_in.mw),
        .MemtoReg_id(id_in.m2r), .ALUSrc_id(id_in.as), .Branch_id(id_in.br),
        .ALUOp_id(id_in.op), .uses_rs2_id(id_in.u2), .valid_id(id_in.v),
        .flush(flush), .hold(hold),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .pc_ex(pc_ex),
        .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
        .MemtoReg_ex(MemtoReg_ex), .ALUSrc_ex(ALUSrc_ex), .Branch_ex(Branch_ex),
        .ALUOp_ex(ALUOp_ex), .uses_rs2_ex(uses_rs2_ex), .valid_ex(valid_ex),
        .stall(stall), .stall_count(stall_count)
    );

    assign act = {rs1_ex, rs2_ex, rd_ex, rs1_data_ex, rs2_data_ex, imm_ex, pc_ex,
                  RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, ALUSrc_ex, Branch_ex,
                  ALUOp_ex, uses_rs2_ex, valid_ex};

    task automatic chk(input string nm, input logic [159:0] a, input logic [159:0] e);
        n_vec++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic logic [159:0] ctrl(input rec_t r);
        return 160'({r.rd, r.rw, r.mr, r.mw, r.m2r, r.as, r.br, r.op, r.v});
    endfunction

    function automatic logic [159:0] opnd(input rec_t r);
        return 160'({r.rs1, r.rs2, r.d1, r.d2, r.imm, r.pc, r.u2});
    endfunction

    function automatic rec_t ins(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                 input logic [31:0] imm, input logic ld, input logic u2,
                                 input logic v);
        rec_t r;
        r.rs1 = r1;
        r.rs2 = r2;
        r.rd  = rd;
        r.d1  = 32'hA000_0000 + {27'd0, r1};
        r.d2  = 32'hB000_0000 + {27'd0, r2};
        r.imm = imm;
        r.pc  = 32'h0000_0400 + {25'd0, rd, 2'b00};
        r.rw  = 1'b1;
        r.mr  = ld;
        r.mw  = 1'b0;
        r.m2r = ld;
        r.as  = ~u2;
        r.br  = 1'b0;
        r.op  = ld ? 2'b00 : 2'b10;
        r.u2  = u2;
        r.v   = v;
        return r;
    endfunction

    function automatic rec_t strip(input rec_t r);
        rec_t s;
        s     = r;
        s.rd  = 5'd0;
        s.rw  = 1'b0;
        s.mr  = 1'b0;
        s.mw  = 1'b0;
        s.m2r = 1'b0;
        s.as  = 1'b0;
        s.br  = 1'b0;
        s.op  = 2'b00;
        s.v   = 1'b0;
        return s;
    endfunction

    // Drive one ID-stage cycle; kind names the hand-derived outcome of the next edge.
    task automatic vec(input rec_t id, input logic fl, input logic hd, input int kind,
                       input logic st, input logic [15:0] cnt);
        exp_t x;
        @(negedge clk);
        id_in = id;
        flush = fl;
        hold  = hd;
        case (kind)
            K_LOAD:  x.e = id.v ? id : strip(id);
            K_HAZ:   x.e = strip(id);
            K_HOLD:  x.e = prev_e;
            default: x.e = '0;
        endcase
        x.dc    = (kind == K_HAZ);
        x.stall = st;
        x.cnt   = cnt;
        prev_e  = x.e;
        sbq.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        logic s;
        forever begin
            @(negedge clk);
            #2 s = stall;
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                x = sbq.pop_front();
                chk("stall", 160'(s), 160'(x.stall));
                chk("stall_count", 160'(stall_count), 160'(x.cnt));
                chk("ctrl_rd_valid", ctrl(act), ctrl(x.e));
                if (!x.dc) chk("operands", opnd(act), opnd(x.e));
            end
        end
    end

    initial begin : driver
        rst_n  = 1'b0;
        id_in  = '0;
        flush  = 1'b0;
        hold   = 1'b0;
        prev_e = '0;
        #7;
        chk("reset_ex", 160'(act), 160'd0);
        chk("reset_count", 160'(stall_count), 160'd0);
        chk("reset_stall_nohold", 160'(stall), 160'd0);
        hold = 1'b1;
        #1 chk("reset_stall_hold", 160'(stall), 160'd1);
        hold  = 1'b0;
        rst_n = 1'b1;

        vec(ins(5'd1, 5'd0, 5'd5, 32'h0,  1'b1, 1'b0, 1'b1), 0, 0, K_LOAD, 0, 16'd0);
        vec(ins(5'd5, 5'd2, 5'd6, 32'h0,  1'b0, 1'b1, 1'b1), 0, 0, K_HAZ,  1, 16'd1);
        vec(ins(5'd5, 5'd2, 5'd6, 32'h0,  1'b0, 1'b1, 1'b1), 0, 0, K_LOAD, 0, 16'd1);
        vec(ins(5'd3, 5'd0, 5'd5, 32'h4,  1'b1, 1'b0, 1'b1), 0, 0, K_LOAD, 0, 16'd1);
        vec(ins(5'd8, 5'd5, 5'd7, 32'h9,  1'b0, 1'b0, 1'b1), 0, 0, K_LOAD, 0, 16'd1);
        vec(ins(5'd1, 5'd0, 5'd0, 32'h8,  1'b1, 1'b0, 1'b1), 0, 0, K_LOAD, 0, 16'd1);
        vec(ins(5'd0, 5'd0, 5'd9, 32'h0,  1'b0, 1'b1, 1'b1), 0, 0, K_LOAD, 0, 16'd1);
        vec(ins(5'd2, 5'd0, 5'd7, 32'h10, 1'b1, 1'b0, 1'b1), 0, 0, K_LOAD, 0, 16'd1);
        for (int i = 0; i < 3; i++)
            vec(ins(5'd7, 5'd7, 5'd11, 32'h0, 1'b0, 1'b1, 1'b1), 0, 1, K_HOLD, 1, 16'd1);
        vec(ins(5'd7, 5'd7, 5'd11, 32'h0, 1'b0, 1'b1, 1'b1), 1, 1, K_BUB,  0, 16'd1);
        vec(ins(5'd1, 5'd2, 5'd12, 32'h0, 1'b1, 1'b1, 1'b0), 0, 0, K_LOAD, 0, 16'd1);
        vec(ins(5'd1, 5'd0, 5'd5, 32'h0,  1'b1, 1'b0, 1'b1), 0, 0, K_LOAD, 0, 16'd1);
        vec(ins(5'd3, 5'd5, 5'd10, 32'h0, 1'b0, 1'b1, 1'b1), 0, 0, K_HAZ,  1, 16'd2);
        vec(ins(5'd3, 5'd5, 5'd10, 32'h0, 1'b0, 1'b1, 1'b1), 0, 0, K_LOAD, 0, 16'd2);
        vec(ins(5'd1, 5'd0, 5'd4, 32'h0,  1'b1, 1'b0, 1'b1), 0, 0, K_LOAD, 0, 16'd2);
        vec(ins(5'd4, 5'd0, 5'd13, 32'h0, 1'b0, 1'b1, 1'b0), 0, 0, K_LOAD, 0, 16'd2);
        vec(ins(5'd1, 5'd0, 5'd5, 32'h0,  1'b1, 1'b0, 1'b1), 0, 0, K_LOAD, 0, 16'd2);

        // preset the counter just below saturation
        @(posedge clk);
        #2 force dut.stall_count_q = 16'hFFFE;
        #1 release dut.stall_count_q;
        chk("preset_count", 160'(stall_count), 160'(16'hFFFE));

        vec(ins(5'd5, 5'd0, 5'd6, 32'h0, 1'b0, 1'b1, 1'b1), 0, 0, K_HAZ,  1, 16'hFFFF);
        vec(ins(5'd5, 5'd0, 5'd6, 32'h0, 1'b0, 1'b1, 1'b1), 0, 0, K_LOAD, 0, 16'hFFFF);
        vec(ins(5'd1, 5'd0, 5'd5, 32'h0, 1'b1, 1'b0, 1'b1), 0, 0, K_LOAD, 0, 16'hFFFF);
        vec(ins(5'd5, 5'd0, 5'd6, 32'h0, 1'b0, 1'b1, 1'b1), 0, 0, K_HAZ,  1, 16'hFFFF);
        vec(ins(5'd5, 5'd0, 5'd6, 32'h0, 1'b0, 1'b1, 1'b1), 0, 0, K_LOAD, 0, 16'hFFFF);
        vec(ins(5'd1, 5'd0, 5'd5, 32'h0, 1'b1, 1'b0, 1'b1), 0, 0, K_LOAD, 0, 16'hFFFF);
        vec(ins(5'd5, 5'd0, 5'd6, 32'h0, 1'b0, 1'b1, 1'b1), 0, 1, K_HOLD, 1, 16'hFFFF);

        // asynchronous reset between edges while holding a RegWrite load
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ex", 160'(act), 160'd0);
        chk("async_reset_regwrite", 160'(RegWrite_ex), 160'd0);
        chk("async_reset_count", 160'(stall_count), 160'd0);
        chk("async_reset_stall_hold", 160'(stall), 160'd1);
        hold = 1'b0;
        #1 chk("async_reset_stall_nohold", 160'(stall), 160'd0);
        rst_n  = 1'b1;
        prev_e = '0;

        vec(ins(5'd1, 5'd0, 5'd5, 32'h0, 1'b1, 1'b0, 1'b1), 0, 0, K_LOAD, 0, 16'd0);
        vec(ins(5'd5, 5'd0, 5'd6, 32'h0, 1'b0, 1'b1, 1'b1), 0, 0, K_HAZ,  1, 16'd1);
        vec(ins(5'd5, 5'd0, 5'd6, 32'h0, 1'b0, 1'b1, 1'b1), 0, 0, K_LOAD, 0, 16'd1);

        for (int i = 0; i < 5 && sbq.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 160'(sbq.size()), 160'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
